vram_arbiter: RTL

//  Shares one single-port synchronous VRAM between two requesters.
//  - Display fetch port: the VGA scanout pixel fetch. It is latency-sensitive and has priority.
//  - CPU port: VDP data-port reads and writes.
//  One memory access is issued per clk_50 cycle. A bounded-wait counter keeps the CPU from starving.

---
 rtl/vram_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Shares one single-port synchronous VRAM between the display
//            scanout fetch (priority) and the CPU data port. One access is
//            issued per clock; a bounded-wait counter stops CPU starvation.
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
    parameter int AW       = 14,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 7
) (
    input  logic          clk_50,
    input  logic          rst_n,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_valid,
    output logic [DW-1:0] disp_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          ovf_clr,
    output logic          disp_ovf
);

    localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

    // Grant encoding for the access issued this cycle
    localparam logic [1:0] c_G_IDLE = 2'd0;
    localparam logic [1:0] c_G_DISP = 2'd1;
    localparam logic [1:0] c_G_CPU  = 2'd2;

    logic          r_disp_pend;
    logic [AW-1:0] r_disp_addr_q;
    logic          r_disp_ovf;
    logic          r_cpu_lock;
    logic [7:0]    r_wait_cnt;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_we;
    logic [DW-1:0] r_mem_wdata;
    logic          r_cpu_rd_tag;
    logic          r_cpu_ack;
    logic          r_disp_rd_tag;
    logic          r_disp_valid;

    logic          w_cpu_elig;
    logic [1:0]    w_grant;

    // The CPU may not re-issue while its previous access is still in flight
    assign w_cpu_elig = cpu_req & ~r_cpu_lock & ~r_cpu_ack;

    // Pick this cycle's access: display has priority unless the CPU has waited long enough
    always_comb begin
        w_grant = c_G_IDLE;
        if (w_cpu_elig && (!r_disp_pend || (r_wait_cnt == c_MAX_WAIT))) begin
            w_grant = c_G_CPU;
        end else if (r_disp_pend) begin
            w_grant = c_G_DISP;
        end
    end

    // Capture display requests; a newer request always replaces the held address
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_pend   <= 1'b0;
            r_disp_addr_q <= '0;
        end else if (disp_req) begin
            r_disp_pend   <= 1'b1;
            r_disp_addr_q <= disp_addr;
        end else if (w_grant == c_G_DISP) begin
            r_disp_pend   <= 1'b0;
        end
    end

    // Sticky overflow: a pending, unserved request was overwritten; clear wins
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_ovf <= 1'b0;
        end else if (ovf_clr) begin
            r_disp_ovf <= 1'b0;
        end else if (r_disp_pend && (w_grant != c_G_DISP) && disp_req) begin
            r_disp_ovf <= 1'b1;
        end
    end

    // Lock the CPU port from grant until its acknowledge cycle
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_lock <= 1'b0;
        end else if (w_grant == c_G_CPU) begin
            r_cpu_lock <= 1'b1;
        end else if (r_cpu_ack) begin
            r_cpu_lock <= 1'b0;
        end
    end

    // Count eligible CPU cycles lost to display, saturating at the pre-empt threshold
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if ((w_grant == c_G_CPU) || !cpu_req) begin
            r_wait_cnt <= '0;
        end else if (w_cpu_elig && (w_grant == c_G_DISP) && (r_wait_cnt < c_MAX_WAIT)) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // Register the granted access onto the VRAM port; idle holds the address
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            case (w_grant)
                c_G_CPU: begin
                    r_mem_addr  <= cpu_addr;
                    r_mem_we    <= cpu_we;
                    r_mem_wdata <= cpu_wdata;
                end
                c_G_DISP: begin
                    r_mem_addr  <= r_disp_addr_q;
                    r_mem_we    <= 1'b0;
                end
                default: begin
                    r_mem_we    <= 1'b0;
                end
            endcase
        end
    end

    // Track who owns the read data returning one cycle after the address
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_rd_tag  <= 1'b0;
            r_cpu_ack     <= 1'b0;
            r_disp_rd_tag <= 1'b0;
            r_disp_valid  <= 1'b0;
        end else begin
            r_cpu_rd_tag  <= (w_grant == c_G_CPU) & ~cpu_we;
            r_cpu_ack     <= ((w_grant == c_G_CPU) & cpu_we) | r_cpu_rd_tag;
            r_disp_rd_tag <= (w_grant == c_G_DISP);
            r_disp_valid  <= r_disp_rd_tag;
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;
    assign cpu_ack    = r_cpu_ack;
    assign disp_valid = r_disp_valid;
    assign disp_ovf   = r_disp_ovf;
    assign disp_rdata = r_disp_valid ? mem_rdata : '0;
    assign cpu_rdata  = r_cpu_ack ? mem_rdata : '0;

endmodule
`default_nettype wire
